// File: rtl/tcm_stream_dma_pkg.sv
// Shared definitions for the TCM byte-stream DMA: FSM states and direction codes.
package tcm_stream_dma_pkg;

  localparam logic DIR_WR = 1'b0;  // stream -> TCM
  localparam logic DIR_RD = 1'b1;  // TCM -> stream

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WRITE = 3'd2,
    S_FETCH = 3'd3,
    S_WAIT  = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/tcm_byte_lane.sv
// Lane counter plus word pack/unpack register. Pushes place bytes little-endian
// by lane; pops shift the word right so the current byte is always in [7:0].
module tcm_byte_lane #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [XLEN-1:0]   load_data_i,
  input  logic              push_i,
  input  logic [7:0]        push_data_i,
  input  logic              pop_i,
  output logic [XLEN-1:0]   word_o,
  output logic [XLEN/8-1:0] be_o,
  output logic [7:0]        byte_o,
  output logic              last_o
);
  localparam int BPW = XLEN / 8;
  localparam int LW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [LW-1:0]   r_lane;
  logic [XLEN-1:0] r_data;
  logic [BPW-1:0]  r_be;

  // Pack/unpack register; clear wins so a new word never inherits stale lanes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lane <= '0;
      r_data <= '0;
      r_be   <= '0;
    end else if (clear_i) begin
      r_lane <= '0;
      r_data <= '0;
      r_be   <= '0;
    end else if (load_i) begin
      r_lane <= '0;
      r_data <= load_data_i;
      r_be   <= '1;
    end else if (push_i) begin
      r_data[{r_lane, 3'b000} +: 8] <= push_data_i;
      r_be[r_lane]                  <= 1'b1;
      r_lane                        <= r_lane + LW'(1);
    end else if (pop_i) begin
      r_data <= r_data >> 8;
      r_lane <= r_lane + LW'(1);
    end
  end

  assign word_o = r_data;
  assign be_o   = r_be;
  assign byte_o = r_data[7:0];
  assign last_o = (r_lane == LW'(BPW - 1));

endmodule

// File: rtl/tcm_stream_dma.sv
// Byte-stream DMA on one TCM port: packs a byte stream into words (write) or
// unpacks fetched words onto a byte stream (read), with a running byte checksum.
module tcm_stream_dma
  import tcm_stream_dma_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int N_ENTRIES = 1024,
  parameter int ADDRW     = $clog2(N_ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              dir_i,
  input  logic [ADDRW-1:0]  base_i,
  input  logic [ADDRW+2:0]  nbytes_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [XLEN-1:0]   sum_o,
  input  logic [7:0]        s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [7:0]        m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              en_o,
  output logic              we_o,
  output logic [XLEN/8-1:0] be_o,
  output logic [ADDRW-1:0]  addr_o,
  output logic [XLEN-1:0]   wdata_o,
  input  logic [XLEN-1:0]   rdata_i,
  input  logic              ready_i
);
  localparam int BPW  = XLEN / 8;
  localparam int LENW = ADDRW + 3;
  localparam int ENDW = ADDRW + 4;

  state_e          r_state, w_next;
  logic [ADDRW-1:0] r_addr;
  logic [LENW-1:0]  r_remain;
  logic [XLEN-1:0]  r_sum;
  logic             r_err;

  logic [ENDW-1:0] w_end;
  logic            w_bad, w_accept, w_push, w_pop, w_clear, w_load, w_last_byte;
  logic            w_lane_last;
  logic [XLEN-1:0] w_word;
  logic [BPW-1:0]  w_be;
  logic [7:0]      w_byte, w_hs_byte;

  // End-of-transfer byte address computed one bit wider so it cannot overflow.
  assign w_end       = ({4'b0000, base_i} * ENDW'(BPW)) + {1'b0, nbytes_i};
  assign w_bad       = (nbytes_i == '0) || (w_end > ENDW'(N_ENTRIES * BPW));
  assign w_accept    = (r_state == S_IDLE) && start_i && !w_bad;
  assign w_push      = (r_state == S_FILL) && s_valid_i;
  assign w_pop       = (r_state == S_DRAIN) && m_ready_i;
  assign w_clear     = w_accept || (r_state == S_WRITE);
  assign w_load      = (r_state == S_WAIT) && ready_i;
  assign w_last_byte = (r_remain == LENW'(1));
  assign w_hs_byte   = w_push ? s_data_i : w_byte;

  tcm_byte_lane #(.XLEN(XLEN)) u_lane (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (w_clear),
    .load_i      (w_load),
    .load_data_i (rdata_i),
    .push_i      (w_push),
    .push_data_i (s_data_i),
    .pop_i       (w_pop),
    .word_o      (w_word),
    .be_o        (w_be),
    .byte_o      (w_byte),
    .last_o      (w_lane_last)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state and per-state control outputs.
  always_comb begin
    w_next    = r_state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    s_ready_o = 1'b0;
    m_valid_o = 1'b0;
    en_o      = 1'b0;
    we_o      = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (dir_i == DIR_RD) ? S_FETCH : S_FILL;
      S_FILL: begin
        busy_o    = 1'b1;
        s_ready_o = 1'b1;
        if (w_push && (w_lane_last || w_last_byte)) w_next = S_WRITE;
      end
      S_WRITE: begin
        busy_o = 1'b1;
        en_o   = 1'b1;
        we_o   = 1'b1;
        w_next = (r_remain == '0) ? S_DONE : S_FILL;
      end
      S_FETCH: begin
        busy_o = 1'b1;
        en_o   = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        busy_o = 1'b1;
        if (ready_i) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy_o    = 1'b1;
        m_valid_o = 1'b1;
        if (w_pop) begin
          if (w_last_byte)      w_next = S_DONE;
          else if (w_lane_last) w_next = S_FETCH;
        end
      end
      S_DONE:  begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Length/address counters, checksum and the registered reject pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr   <= '0;
      r_remain <= '0;
      r_sum    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= (r_state == S_IDLE) && start_i && w_bad;
      if (w_accept) begin
        r_addr   <= base_i;
        r_remain <= nbytes_i;
        r_sum    <= '0;
      end else begin
        if (w_push || w_pop) begin
          r_remain <= r_remain - LENW'(1);
          r_sum    <= r_sum + XLEN'(w_hs_byte);
        end
        if ((r_state == S_WRITE) || (w_pop && w_lane_last && !w_last_byte))
          r_addr <= r_addr + ADDRW'(1);
      end
    end
  end

  // TCM and stream data are forced to zero outside their qualifying strobes.
  assign addr_o   = en_o ? r_addr : '0;
  assign wdata_o  = we_o ? w_word : '0;
  assign be_o     = we_o ? w_be : '0;
  assign m_data_o = m_valid_o ? w_byte : '0;
  assign sum_o    = r_sum;
  assign err_o    = r_err;

endmodule
